// File: rtl/submatrix_pkg.sv
// Shared definitions for the submatrix writer/grouper pair: word width,
// default image end address and FSM state encoding.
package submatrix_pkg;

  localparam int SUBM_WORD_W = 16;
  localparam logic [15:0] SUBM_LAST_ADDR = 16'hFFFF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/submatrix_writer_addr.sv
// Bit-address generator for the result-image RAM; advances only on writes,
// with a synchronous clear used when the image wraps.
module write_addr_counter #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en_i,
  input  logic              clr_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (en_i) addr_d = clr_i ? '0 : addr_q + ADDR_W'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) addr_q <= '0;
    else         addr_q <= addr_d;
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/submatrix_writer.sv
// Serializes grouped 16-bit submatrix words MSB-first into single-bit RAM writes.
// Define SUBMATRIX_WRITER_WRAP_EN to wrap at LAST_ADDR instead of stopping (FULL).
module submatrix_writer
  import submatrix_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter int                WORD_W    = SUBM_WORD_W,
  parameter logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SUBM_LAST_ADDR)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  input  logic [WORD_W-1:0] dataIn,
  input  logic              loaded,
  output logic              readyToBeLoaded,
  output logic [ADDR_W-1:0] memAddress,
  output logic              wrData,
  output logic              wren,
  output logic              done
);

  localparam int CNT_W = $clog2(WORD_W);

  logic [1:0]        state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] addr;
  logic              writing, last_bit, at_last, wrap_clr, stop, accept;

  assign writing  = enable && (state_q == ST_SHIFT);
  assign last_bit = (bitcnt_q == CNT_W'(WORD_W - 1));
  assign at_last  = writing && (addr == LAST_ADDR);

`ifdef SUBMATRIX_WRITER_WRAP_EN
  assign wrap_clr = at_last;
  assign stop     = 1'b0;
`else
  assign wrap_clr = 1'b0;
  // The final image write takes precedence over a back-to-back reload.
  assign stop     = at_last;
`endif

  assign readyToBeLoaded = enable && resetn && !stop &&
                           ((state_q == ST_IDLE) || ((state_q == ST_SHIFT) && last_bit));
  assign accept = loaded && readyToBeLoaded;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    done_d   = done_q;
    if (enable) begin
`ifdef SUBMATRIX_WRITER_WRAP_EN
      done_d = wrap_clr;
`endif
      if (accept) begin
        state_d  = ST_SHIFT;
        shreg_d  = dataIn;
        bitcnt_d = '0;
      end else if (stop) begin
        state_d = ST_FULL;
        done_d  = 1'b1;
      end else if (writing) begin
        shreg_d  = shreg_q << 1;
        bitcnt_d = bitcnt_q + CNT_W'(1);
        if (last_bit) state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      done_q   <= done_d;
    end
  end

  write_addr_counter #(.ADDR_W(ADDR_W)) u_addr (
    .clk    (clk),
    .resetn (resetn),
    .en_i   (writing),
    .clr_i  (wrap_clr),
    .addr_o (addr)
  );

  assign memAddress = addr;
  assign wren       = writing;
  assign wrData     = writing && shreg_q[WORD_W-1];
  assign done       = done_q;

endmodule

// File: tb/tb_submatrix_writer.sv
// Randomized and directed bench for submatrix_writer against a bit-queue model.
module tb_submatrix_writer;

  localparam logic [15:0] LAST = 16'h001F;
`ifdef SUBMATRIX_WRITER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] dataIn = '0;
  logic        loaded = 1'b0;
  logic        readyToBeLoaded;
  logic [15:0] memAddress;
  logic        wrData, wren, done;

  submatrix_writer #(.ADDR_W(16), .WORD_W(16), .LAST_ADDR(LAST)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .enable          (enable),
    .dataIn          (dataIn),
    .loaded          (loaded),
    .readyToBeLoaded (readyToBeLoaded),
    .memAddress      (memAddress),
    .wrData          (wrData),
    .wren            (wren),
    .done            (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: pending pixel bits in write order, next address, full/done flags.
  bit          q_bits[$];
  logic [15:0] m_addr;
  bit          m_full, m_done;

  // Observations of the most recent cycle, for scenario-level checks.
  logic        obs_wren, obs_bit, obs_rdy, obs_done;
  logic [15:0] obs_addr;
  bit          m_acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_bits.delete();
    m_addr = '0;
    m_full = 1'b0;
    m_done = 1'b0;
  endtask

  // Entered and left at posedge+1; outputs compared at the negedge.
  task automatic cycle(input logic en, input logic ld, input logic [15:0] din);
    bit e_wren, e_bit, e_rdy, last_hit;
    enable = en; loaded = ld; dataIn = din;
    @(negedge clk);
    e_wren   = en && (q_bits.size() > 0);
    e_bit    = e_wren ? q_bits[0] : 1'b0;
    last_hit = e_wren && (m_addr == LAST);
    e_rdy    = en && !m_full && (q_bits.size() <= 1) && !(last_hit && !WRAP);
    obs_wren = wren; obs_bit = wrData; obs_rdy = readyToBeLoaded;
    obs_addr = memAddress; obs_done = done;
    chk("wren", 32'(wren), 32'(e_wren));
    chk("wrData", 32'(wrData), 32'(e_bit));
    chk("ready", 32'(readyToBeLoaded), 32'(e_rdy));
    chk("memAddress", 32'(memAddress), 32'(m_addr));
    chk("done", 32'(done), 32'(m_done));
    @(posedge clk);
    m_acc = ld && e_rdy;
    if (en) begin
      if (WRAP) m_done = last_hit;
      if (e_wren) begin
        void'(q_bits.pop_front());
        if (last_hit && WRAP) m_addr = '0;
        else                  m_addr = m_addr + 16'd1;
        if (last_hit && !WRAP) begin
          m_full = 1'b1;
          m_done = 1'b1;
          q_bits.delete();
        end
      end
      if (m_acc) for (int i = 15; i >= 0; i--) q_bits.push_back(din[i]);
    end
    #1;
  endtask

  // Asynchronous reset pulse away from clock edges; outputs must clear at once.
  task automatic async_reset();
    #2;
    loaded = 1'b0;
    resetn = 1'b0;
    #1;
    chk("rst_wren", 32'(wren), 32'd0);
    chk("rst_wrData", 32'(wrData), 32'd0);
    chk("rst_ready", 32'(readyToBeLoaded), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(memAddress), 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    logic [15:0] bits;
    int cnt, dcnt, low_writes;
    logic [15:0] words[3];

    model_reset();
    @(posedge clk); #1;
    async_reset();

    // Single word A5C3: 16 writes at 0..15, ready again on the last bit.
    cycle(1, 1, 16'hA5C3);
    bits = '0;
    for (int i = 0; i < 16; i++) begin
      cycle(1, 0, 16'h0);
      bits = {bits[14:0], obs_bit};
      chk("a5c3_addr", 32'(obs_addr), i);
      if (i == 15) chk("a5c3_ready16", 32'(obs_rdy), 32'd1);
    end
    chk("a5c3_bits", 32'(bits), 32'hA5C3);
    cycle(1, 0, 16'h0);
    chk("a5c3_idle_wren", 32'(obs_wren), 32'd0);

    // Back-to-back FFFF then 0000 with loaded held: 32 contiguous writes.
    async_reset();
    cycle(1, 1, 16'hFFFF);
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      cycle(1, (i < 16), 16'h0000);
      if (obs_wren) cnt++;
      chk("b2b_addr", 32'(obs_addr), i);
    end
    chk("b2b_wren_count", cnt, 32);

    // Enable dropped for three cycles after the fifth bit of 8001.
    async_reset();
    cycle(1, 1, 16'h8001);
    for (int i = 0; i < 5; i++) cycle(1, 0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 16'hFFFF);
      chk("gate_wren", 32'(obs_wren), 32'd0);
    end
    cycle(1, 0, 16'h0);
    chk("gate_resume_addr", 32'(obs_addr), 32'd5);
    for (int i = 0; i < 10; i++) cycle(1, 0, 16'h0);
    chk("gate_last_bit", 32'(obs_bit), 32'd1);

    // Three words streamed into a 32-bit image.
    async_reset();
    words[0] = 16'h1234; words[1] = 16'hBEEF; words[2] = 16'hC001;
    cnt = 0; dcnt = 0; low_writes = 0;
    for (int i = 0; i < 60; i++) begin
      cycle(1, (cnt < 3), (cnt < 3) ? words[cnt] : 16'h0);
      if (obs_done) dcnt++;
      if (obs_wren && dcnt > 0) low_writes++;
      if (m_acc) cnt++;
    end
    if (WRAP) begin
      chk("wrap_done_pulses", dcnt, 1);
      chk("wrap_third_writes", low_writes, 16);
      chk("wrap_accepted", cnt, 3);
    end else begin
      chk("full_done_sticky", 32'(obs_done), 32'd1);
      chk("full_ready_low", 32'(obs_rdy), 32'd0);
      chk("full_accepted", cnt, 2);
    end

    // Reset mid-word at bit 7, then a new word starts at address 0.
    async_reset();
    cycle(1, 1, 16'hF0F0);
    for (int i = 0; i < 7; i++) cycle(1, 0, 16'h0);
    async_reset();
    cycle(1, 0, 16'h0);
    chk("rstmid_no_write", 32'(obs_wren), 32'd0);
    cycle(1, 1, 16'h5555);
    cycle(1, 0, 16'h0);
    chk("rstmid_restart_addr", 32'(obs_addr), 32'd0);
    chk("rstmid_restart_wren", 32'(obs_wren), 32'd1);

    // Randomized traffic with occasional asynchronous resets.
    for (int r = 0; r < 6; r++) begin
      async_reset();
      for (int i = 0; i < 250; i++) begin
        cycle(($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 60),
              16'($urandom()));
        if ($urandom_range(0, 199) == 0) async_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
